// File: rtl/udt_pkg.sv
// Shared definitions for the UDT packet decoder: header size, control types, FSM encoding
// and header parsing helpers.
package udt_pkg;

  localparam int unsigned UDT_HDR_BYTES = 16;

  localparam logic [14:0] UDT_T_HS   = 15'd0;
  localparam logic [14:0] UDT_T_KA   = 15'd1;
  localparam logic [14:0] UDT_T_ACK  = 15'd2;
  localparam logic [14:0] UDT_T_NAK  = 15'd3;
  localparam logic [14:0] UDT_T_SHUT = 15'd5;
  localparam logic [14:0] UDT_T_ACK2 = 15'd6;
  localparam logic [14:0] UDT_T_DROP = 15'd7;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic        ctrl;
    logic [14:0] ctype;
    logic [30:0] word0;
    logic [31:0] word1;
    logic [31:0] ts;
    logic [31:0] sock;
  } udt_hdr_t;

  // Wire byte 0 sits in bits [7:0]; header words are big-endian.
  function automatic logic [31:0] be_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic udt_hdr_t parse_hdr(input logic [127:0] raw);
    udt_hdr_t   h;
    logic [31:0] w0;
    w0      = be_word(raw[31:0]);
    h.ctrl  = w0[31];
    h.ctype = w0[31] ? w0[30:16] : 15'd0;
    h.word0 = w0[30:0];
    h.word1 = be_word(raw[63:32]);
    h.ts    = be_word(raw[95:64]);
    h.sock  = be_word(raw[127:96]);
    return h;
  endfunction

endpackage

// File: rtl/udt_axis_skid.sv
// Two-entry register slice; ready_o depends only on occupancy so it never combinationally
// follows ready_i.
module udt_axis_skid #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push, pop;

  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/udt_pkt_decoder.sv
// UDT packet decoder: parses the 16-byte header, classifies the packet, filters by socket ID
// and forwards the header-stripped body through a register slice.
module udt_pkt_decoder
  import udt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter bit          SOCK_FILTER_EN = 1'b1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                    core_clk,
  input  logic                    core_rst,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic                    in_tlast,
  output logic [DATA_WIDTH-1:0]   out_tdata,
  output logic [DATA_WIDTH/8-1:0] out_tkeep,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic                    out_tctrl,
  input  logic [31:0]             cfg_sock_id,
  output logic                    hdr_valid,
  output logic                    hdr_ctrl,
  output logic [14:0]             hdr_type,
  output logic [30:0]             hdr_word0,
  output logic [31:0]             hdr_word1,
  output logic [31:0]             hdr_ts,
  output logic [31:0]             hdr_sock,
  output logic                    Data_en,
  output logic                    Handshake_en,
  output logic                    Keep_live_en,
  output logic                    ACK_en,
  output logic                    NAK_en,
  output logic                    ACK2_en,
  output logic                    Shutdown_en,
  output logic                    Drop_en,
  output logic                    Runt_err,
  output logic                    Unknown_err,
  output logic                    Sock_miss,
  output logic [CNT_WIDTH-1:0]    cnt_pkts,
  output logic [CNT_WIDTH-1:0]    cnt_drop
);

  localparam int unsigned KeepW = DATA_WIDTH / 8;
  localparam int unsigned SkidW = DATA_WIDTH + KeepW + 2;

  logic [1:0]           state_q, state_d;
  logic                 rdy_q;
  logic                 ctrl_q, ctrl_d;
  logic [127:0]         hdr_raw;
  logic                 hdr_final, hdr_prior_bad;
  logic                 in_acc, hdr_acc, body_push, skid_in_ready;
  udt_hdr_t             hdr, hdr_q;
  logic                 keep_bad, sock_bad, type_ok;
  logic                 good_d, runt_d, miss_d, unk_d;
  logic [7:0]           type_vec_d, type_vec_q;
  logic                 hdr_valid_q, runt_q, miss_q, unk_q;
  logic [CNT_WIDTH-1:0] pkts_q, pkts_d, drop_q, drop_d;
  logic [SkidW-1:0]     skid_out;

  assign in_tready = rdy_q & ((state_q != ST_BODY) | skid_in_ready);
  assign in_acc    = in_tvalid & in_tready;
  assign hdr_acc   = in_acc & (state_q == ST_HDR);
  assign body_push = in_tvalid & rdy_q & (state_q == ST_BODY);

  if (DATA_WIDTH == 64) begin : g_hdr64
    logic                  beat_q, bad_q;
    logic [DATA_WIDTH-1:0] lo_q;

    always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
        beat_q <= 1'b0;
        bad_q  <= 1'b0;
        lo_q   <= '0;
      end else if (hdr_acc) begin
        if (!beat_q && !in_tlast) begin
          beat_q <= 1'b1;
          bad_q  <= (in_tkeep != '1);
          lo_q   <= in_tdata;
        end else begin
          beat_q <= 1'b0;
          bad_q  <= 1'b0;
        end
      end
    end

    assign hdr_raw       = {in_tdata, lo_q};
    assign hdr_final     = beat_q;
    assign hdr_prior_bad = bad_q;
  end else if (DATA_WIDTH == 128) begin : g_hdr128
    assign hdr_raw       = in_tdata;
    assign hdr_final     = 1'b1;
    assign hdr_prior_bad = 1'b0;
  end else begin : g_hdr_bad
    $error("udt_pkt_decoder: DATA_WIDTH must be 64 or 128");
    assign hdr_raw       = '0;
    assign hdr_final     = 1'b1;
    assign hdr_prior_bad = 1'b0;
  end

  assign hdr      = parse_hdr(hdr_raw);
  assign keep_bad = (in_tkeep != '1) | hdr_prior_bad;
  assign sock_bad = SOCK_FILTER_EN && (hdr.sock != cfg_sock_id);
  assign type_ok  = !hdr.ctrl || ((hdr.ctype <= UDT_T_DROP) && (hdr.ctype != 15'd4));

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    good_d  = 1'b0;
    runt_d  = 1'b0;
    miss_d  = 1'b0;
    unk_d   = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (hdr_acc) begin
          if (!hdr_final) begin
            runt_d = in_tlast;
          end else begin
            // Only one error is reported per packet; runt wins, then filter, then type.
            if (keep_bad)      runt_d = 1'b1;
            else if (sock_bad) miss_d = 1'b1;
            else if (!type_ok) unk_d  = 1'b1;
            else               good_d = 1'b1;
            ctrl_d = hdr.ctrl;
            if (!in_tlast) state_d = good_d ? ST_BODY : ST_DROP;
          end
        end
      end
      ST_BODY, ST_DROP: begin
        if (in_acc && in_tlast) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_comb begin
    type_vec_d = 8'd0;
    if (good_d) begin
      if (!hdr.ctrl) begin
        type_vec_d[0] = 1'b1;
      end else begin
        case (hdr.ctype)
          UDT_T_HS:   type_vec_d[1] = 1'b1;
          UDT_T_KA:   type_vec_d[2] = 1'b1;
          UDT_T_ACK:  type_vec_d[3] = 1'b1;
          UDT_T_NAK:  type_vec_d[4] = 1'b1;
          UDT_T_SHUT: type_vec_d[5] = 1'b1;
          UDT_T_ACK2: type_vec_d[6] = 1'b1;
          UDT_T_DROP: type_vec_d[7] = 1'b1;
          default:    type_vec_d    = 8'd0;
        endcase
      end
    end
  end

  always_comb begin
    pkts_d = pkts_q;
    drop_d = drop_q;
    if (good_d && (pkts_q != '1)) pkts_d = pkts_q + CNT_WIDTH'(1);
    if ((runt_d || miss_d || unk_d) && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q     <= ST_HDR;
      rdy_q       <= 1'b0;
      ctrl_q      <= 1'b0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      type_vec_q  <= 8'd0;
      runt_q      <= 1'b0;
      miss_q      <= 1'b0;
      unk_q       <= 1'b0;
      pkts_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      ctrl_q      <= ctrl_d;
      hdr_valid_q <= good_d;
      type_vec_q  <= type_vec_d;
      runt_q      <= runt_d;
      miss_q      <= miss_d;
      unk_q       <= unk_d;
      pkts_q      <= pkts_d;
      drop_q      <= drop_d;
      if (good_d) hdr_q <= hdr;
    end
  end

  udt_axis_skid #(
    .Width (SkidW)
  ) u_skid (
    .clk_i   (core_clk),
    .rst_i   (core_rst),
    .valid_i (body_push),
    .ready_o (skid_in_ready),
    .data_i  ({in_tdata, in_tkeep, in_tlast, ctrl_q}),
    .valid_o (out_tvalid),
    .ready_i (out_tready),
    .data_o  (skid_out)
  );

  assign {out_tdata, out_tkeep, out_tlast, out_tctrl} = skid_out;

  assign hdr_valid    = hdr_valid_q;
  assign hdr_ctrl     = hdr_q.ctrl;
  assign hdr_type     = hdr_q.ctype;
  assign hdr_word0    = hdr_q.word0;
  assign hdr_word1    = hdr_q.word1;
  assign hdr_ts       = hdr_q.ts;
  assign hdr_sock     = hdr_q.sock;
  assign Data_en      = type_vec_q[0];
  assign Handshake_en = type_vec_q[1];
  assign Keep_live_en = type_vec_q[2];
  assign ACK_en       = type_vec_q[3];
  assign NAK_en       = type_vec_q[4];
  assign Shutdown_en  = type_vec_q[5];
  assign ACK2_en      = type_vec_q[6];
  assign Drop_en      = type_vec_q[7];
  assign Runt_err     = runt_q;
  assign Unknown_err  = unk_q;
  assign Sock_miss    = miss_q;
  assign cnt_pkts     = pkts_q;
  assign cnt_drop     = drop_q;

endmodule

// File: tb/tb_udt_pkt_decoder.sv
// Directed bench for udt_pkt_decoder at 64-bit width with 4-bit counters.
module tb_udt_pkt_decoder;

  localparam int unsigned DW   = 64;
  localparam int unsigned CW   = 4;
  localparam logic [31:0] SOCK = 32'hCAFE_0001;
  localparam logic [31:0] TS   = 32'h0BAD_F00D;

  logic          core_clk = 1'b0;
  logic          core_rst = 1'b1;
  logic [DW-1:0] in_tdata = '0;
  logic [7:0]    in_tkeep = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tlast = 1'b0;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic [7:0]    out_tkeep;
  logic          out_tvalid, out_tlast, out_tctrl;
  logic          out_tready = 1'b1;
  logic          hdr_valid, hdr_ctrl;
  logic [14:0]   hdr_type;
  logic [30:0]   hdr_word0;
  logic [31:0]   hdr_word1, hdr_ts, hdr_sock;
  logic          Data_en, Handshake_en, Keep_live_en, ACK_en, NAK_en, ACK2_en, Shutdown_en;
  logic          Drop_en, Runt_err, Unknown_err, Sock_miss;
  logic [CW-1:0] cnt_pkts, cnt_drop;

  always #5 core_clk = ~core_clk;

  udt_pkt_decoder #(
    .DATA_WIDTH     (DW),
    .SOCK_FILTER_EN (1'b1),
    .CNT_WIDTH      (CW)
  ) dut (
    .core_clk     (core_clk),
    .core_rst     (core_rst),
    .in_tdata     (in_tdata),
    .in_tkeep     (in_tkeep),
    .in_tvalid    (in_tvalid),
    .in_tready    (in_tready),
    .in_tlast     (in_tlast),
    .out_tdata    (out_tdata),
    .out_tkeep    (out_tkeep),
    .out_tvalid   (out_tvalid),
    .out_tready   (out_tready),
    .out_tlast    (out_tlast),
    .out_tctrl    (out_tctrl),
    .cfg_sock_id  (SOCK),
    .hdr_valid    (hdr_valid),
    .hdr_ctrl     (hdr_ctrl),
    .hdr_type     (hdr_type),
    .hdr_word0    (hdr_word0),
    .hdr_word1    (hdr_word1),
    .hdr_ts       (hdr_ts),
    .hdr_sock     (hdr_sock),
    .Data_en      (Data_en),
    .Handshake_en (Handshake_en),
    .Keep_live_en (Keep_live_en),
    .ACK_en       (ACK_en),
    .NAK_en       (NAK_en),
    .ACK2_en      (ACK2_en),
    .Shutdown_en  (Shutdown_en),
    .Drop_en      (Drop_en),
    .Runt_err     (Runt_err),
    .Unknown_err  (Unknown_err),
    .Sock_miss    (Sock_miss)  ,
    .cnt_pkts     (cnt_pkts),
    .cnt_drop     (cnt_drop)
  );

  int n_chk = 0;
  int n_bad = 0;
  int ev [12];
  int snap [12];
  int overlaps = 0;
  int out_beats = 0, ctrl_beats = 0, snap_beats = 0, snap_ctrl = 0;
  logic [7:0] last_keep = '0;
  byte unsigned exp_q[$];
  byte unsigned act_q[$];
  byte unsigned pkt[$];
  int rdy_mode = 0;
  int exp_pkts = 0, exp_drop = 0, nmis = 0;
  logic [10:0] strb;

  assign strb = {Sock_miss, Unknown_err, Runt_err, Drop_en, ACK2_en, Shutdown_en, NAK_en,
                 ACK_en, Keep_live_en, Handshake_en, Data_en};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Strobes and output beats are sampled mid-cycle, away from the active edge.
  always @(negedge core_clk) begin
    if (!core_rst) begin
      for (int i = 0; i < 11; i++) if (strb[i]) ev[i]++;
      if (hdr_valid) ev[11]++;
      if ($countones(strb) > 1) overlaps++;
      if (out_tvalid && out_tready) begin
        for (int k = 0; k < 8; k++) if (out_tkeep[k]) act_q.push_back(out_tdata[8*k+:8]);
        out_beats++;
        if (out_tctrl) ctrl_beats++;
        if (out_tlast) last_keep = out_tkeep;
      end
    end
  end

  initial begin
    forever begin
      @(posedge core_clk);
      #1;
      case (rdy_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = ($urandom_range(0, 99) >= 30);
        default: out_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int type_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += ev[i];
    return s;
  endfunction

  task automatic take_snap();
    for (int i = 0; i < 12; i++) snap[i] = ev[i];
    snap_beats = out_beats;
    snap_ctrl  = ctrl_beats;
  endtask

  task automatic push_word(input logic [31:0] w);
    pkt.push_back(w[31:24]);
    pkt.push_back(w[23:16]);
    pkt.push_back(w[15:8]);
    pkt.push_back(w[7:0]);
  endtask

  task automatic mk_pkt(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] sock,
                        input int body_len, input int seed, input bit good);
    byte unsigned b;
    pkt.delete();
    push_word(w0);
    push_word(w1);
    push_word(TS);
    push_word(sock);
    for (int i = 0; i < body_len; i++) begin
      b = 8'((seed + i * 7) & 255);
      pkt.push_back(b);
      if (good) exp_q.push_back(b);
    end
  endtask

  task automatic send(input int max_beats);
    int n, nb, guard;
    n  = pkt.size();
    nb = (n + 7) / 8;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      in_tdata = '0;
      in_tkeep = '0;
      for (int k = 0; k < 8; k++) begin
        if (b * 8 + k < n) begin
          in_tdata[8*k+:8] = pkt[b*8+k];
          in_tkeep[k]      = 1'b1;
        end
      end
      in_tlast  = (b == nb - 1);
      in_tvalid = 1'b1;
      guard = 0;
      @(negedge core_clk);
      while (!in_tready && guard < 300) begin
        @(negedge core_clk);
        guard++;
      end
      if (guard >= 300) begin
        check("in_tready_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge core_clk);
      #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0, guard = 0;
    while (quiet < 4 && guard < 500) begin
      @(posedge core_clk);
      #1;
      if (out_tvalid) quiet = 0;
      else quiet++;
      guard++;
    end
    if (guard >= 500) check("drain_timeout", 64'd0, 64'd1);
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    repeat (3) @(posedge core_clk);
    #1;
    check("rst_in_tready", in_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_cnt_pkts", cnt_pkts, 0);
    check("rst_hdr_word0", hdr_word0, 0);
    @(negedge core_clk);
    core_rst = 1'b0;
    @(posedge core_clk);
    #1;
    check("rel_in_tready", in_tready, 1);

    // Data packet, 40-byte body
    take_snap();
    mk_pkt(32'h0000_1234, 32'h0000_00AB, SOCK, 40, 8'h40, 1'b1);
    send(99);
    drain();
    exp_pkts = sat(exp_pkts + 1);
    check("data_en", ev[0] - snap[0], 1);
    check("data_word0", hdr_word0, 31'h1234);
    check("data_ctrl", hdr_ctrl, 0);
    check("data_sock", hdr_sock, SOCK);
    check("data_ts", hdr_ts, TS);
    check("data_beats", out_beats - snap_beats, 5);
    check("data_last_keep", last_keep, 8'hFF);
    check("data_cnt", cnt_pkts, exp_pkts);

    // ACK with 16-byte body
    take_snap();
    mk_pkt(32'h8002_0000, 32'd7, SOCK, 16, 8'h11, 1'b1);
    send(99);
    drain();
    exp_pkts = sat(exp_pkts + 1);
    check("ack_en", ev[3] - snap[3], 1);
    check("ack_word1", hdr_word1, 7);
    check("ack_type", hdr_type, 2);
    check("ack_beats", out_beats - snap_beats, 2);
    check("ack_tctrl", ctrl_beats - snap_ctrl, 2);

    // Keep-alive, header only
    take_snap();
    mk_pkt(32'h8001_0000, 32'd0, SOCK, 0, 0, 1'b1);
    send(99);
    drain();
    exp_pkts = sat(exp_pkts + 1);
    check("ka_en", ev[2] - snap[2], 1);
    check("ka_beats", out_beats - snap_beats, 0);
    check("ka_cnt", cnt_pkts, exp_pkts);

    // 12-byte runt: no type strobe, fields hold the keep-alive header
    take_snap();
    mk_pkt(32'h0000_0001, 32'd0, SOCK, 0, 0, 1'b0);
    repeat (4) void'(pkt.pop_back());
    send(99);
    drain();
    exp_drop = sat(exp_drop + 1);
    check("runt_err", ev[8] - snap[8], 1);
    check("runt_no_type", type_sum() - (snap[0] + snap[1] + snap[2] + snap[3] + snap[4]
                                        + snap[5] + snap[6] + snap[7]), 0);
    check("runt_cnt_drop", cnt_drop, exp_drop);
    check("runt_fields_hold", hdr_word0, 31'h0001_0000);

    // Socket mismatch with body
    take_snap();
    mk_pkt(32'h0000_0055, 32'd0, 32'hDEAD_BEEF, 24, 8'h22, 1'b0);
    send(99);
    drain();
    exp_drop = sat(exp_drop + 1);
    check("sock_miss", ev[10] - snap[10], 1);
    check("sock_beats", out_beats - snap_beats, 0);
    check("sock_cnt_drop", cnt_drop, exp_drop);

    // Unknown control type 4
    take_snap();
    mk_pkt(32'h8004_0000, 32'd0, SOCK, 8, 8'h33, 1'b0);
    send(99);
    drain();
    exp_drop = sat(exp_drop + 1);
    check("unk_err", ev[9] - snap[9], 1);
    check("unk_cnt_drop", cnt_drop, exp_drop);
    check("unk_cnt_pkts", cnt_pkts, exp_pkts);

    // Back-to-back packets with 30% output stall
    take_snap();
    rdy_mode = 1;
    mk_pkt(32'h8000_0000, 32'd1, SOCK, 8, 8'h50, 1'b1);  send(99);
    mk_pkt(32'h8003_0000, 32'd2, SOCK, 13, 8'h60, 1'b1); send(99);
    mk_pkt(32'h8005_0000, 32'd3, SOCK, 0, 8'h70, 1'b1);  send(99);
    mk_pkt(32'h8006_0000, 32'd4, SOCK, 31, 8'h80, 1'b1); send(99);
    mk_pkt(32'h8007_0000, 32'd5, SOCK, 64, 8'h90, 1'b1); send(99);
    mk_pkt(32'h0000_0777, 32'd6, SOCK, 5, 8'hA0, 1'b1);  send(99);
    drain();
    rdy_mode = 0;
    exp_pkts = sat(exp_pkts + 6);
    check("mix_hs", ev[1] - snap[1], 1);
    check("mix_nak", ev[4] - snap[4], 1);
    check("mix_shut", ev[5] - snap[5], 1);
    check("mix_ack2", ev[6] - snap[6], 1);
    check("mix_drop", ev[7] - snap[7], 1);
    check("mix_data", ev[0] - snap[0], 1);
    check("mix_last_keep", last_keep, 8'h1F);
    check("mix_cnt", cnt_pkts, exp_pkts);

    // Reset in the middle of a body with the output stalled
    rdy_mode = 2;
    @(posedge core_clk);
    #1;
    mk_pkt(32'h0000_0042, 32'd0, SOCK, 40, 8'hB0, 1'b0);
    send(3);
    check("pre_rst_valid", out_tvalid, 1);
    @(negedge core_clk);
    core_rst = 1'b1;
    #1;
    check("mid_rst_valid", out_tvalid, 0);
    check("mid_rst_cnt", cnt_pkts, 0);
    check("mid_rst_word0", hdr_word0, 0);
    check("mid_rst_ready", in_tready, 0);
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    core_rst = 1'b0;
    @(posedge core_clk);
    #1;
    rdy_mode = 0;
    exp_pkts = 0;
    exp_drop = 0;
    take_snap();
    mk_pkt(32'h0000_0099, 32'd0, SOCK, 20, 8'hC0, 1'b1);
    send(99);
    drain();
    exp_pkts = sat(exp_pkts + 1);
    check("post_rst_data", ev[0] - snap[0], 1);
    check("post_rst_word0", hdr_word0, 31'h99);
    check("post_rst_cnt", cnt_pkts, exp_pkts);

    // Counter saturation
    for (int i = 0; i < 13; i++) begin
      mk_pkt(32'h8001_0000, 32'd0, SOCK, 0, 0, 1'b1);
      send(99);
    end
    drain();
    exp_pkts = sat(exp_pkts + 13);
    check("sat_pkts_14", cnt_pkts, exp_pkts);
    for (int i = 0; i < 3; i++) begin
      mk_pkt(32'h8001_0000, 32'd0, SOCK, 0, 0, 1'b1);
      send(99);
    end
    for (int i = 0; i < 16; i++) begin
      mk_pkt(32'h0000_0001, 32'd0, SOCK, 0, 0, 1'b0);
      repeat (4) void'(pkt.pop_back());
      send(99);
    end
    drain();
    exp_pkts = sat(exp_pkts + 3);
    exp_drop = sat(exp_drop + 16);
    check("sat_pkts", cnt_pkts, exp_pkts);
    check("sat_drop", cnt_drop, exp_drop);

    check("body_len", act_q.size(), exp_q.size());
    nmis = 0;
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) if (exp_q[i] != act_q[i]) nmis++;
    check("body_bytes", nmis, 0);
    check("no_overlap", overlaps, 0);
    check("hdr_valid_per_type", ev[11], type_sum());

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
